// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   state_t      : divider FSM states (IDLE, CALC, DONE)
//   DIV_WIDTH    : default operand width
//   DBZ_QUOTIENT : quotient reported on divide-by-zero (all ones, truncated to width)
package seq_restoring_divider_pkg;

   localparam int unsigned DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Wide all-ones constant; users truncate it to their operand width.
   localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Ripple trial subtractor computing a - b as a + ~b + 1 over N bits.
//   a, b   : N-bit operands (callers zero-extend by one bit)
//   diff   : low N-1 bits of the difference
//   borrow : MSB of the N-bit difference (1 when a < b for zero-extended inputs)
module trial_subtractor #(
   parameter int unsigned N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-2:0] diff,
   output logic         borrow
);

   logic [N-1:0] nb;
   logic [N-1:0] carry;
   logic [N-1:0] sum;

   assign nb       = ~b;
   assign carry[0] = 1'b1;

   // Full-adder cells chained on the carry.
   for (genvar i = 0; i < N - 1; i++) begin : g_fa
      assign carry[i+1] = (a[i] & nb[i]) | (a[i] & carry[i]) | (nb[i] & carry[i]);
   end

   assign sum    = a ^ nb ^ carry;
   assign diff   = sum[N-2:0];
   assign borrow = sum[N-1];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request pulse, accepted in IDLE or DONE
//   dividend, divisor   : operands, sampled when start is accepted
//   busy                : high while in CALC
//   done                : one-cycle pulse with valid result
//   quotient, remainder : result, held until the next completion
//   div_by_zero         : result flag for a zero divisor, held with the result
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_n;
   logic [WIDTH-1:0] rem_work, rem_n;
   logic [WIDTH-1:0] quo_work, quo_n;
   logic [WIDTH-1:0] divisor_q, divisor_n;
   logic [CW-1:0]    count, count_n;
   logic [WIDTH-1:0] quotient_n, remainder_n;
   logic             busy_n, done_n, dbz_n;

   logic [2*WIDTH-1:0] shifted;
   logic [WIDTH-1:0]   rem_sh, quo_sh;
   logic [WIDTH-1:0]   trial_diff;
   logic               trial_borrow;
   logic [WIDTH-1:0]   step_rem, step_quo;
   logic               accept;

   // One restoring step: shift, trial subtract, keep or restore.
   assign shifted = {rem_work, quo_work} << 1;
   assign rem_sh  = shifted[2*WIDTH-1:WIDTH];
   assign quo_sh  = shifted[WIDTH-1:0];

   trial_subtractor #(.N(WIDTH + 1)) u_trial (
      .a      ({1'b0, rem_sh}),
      .b      ({1'b0, divisor_q}),
      .diff   (trial_diff),
      .borrow (trial_borrow)
   );

   assign step_rem = trial_borrow ? rem_sh : trial_diff;
   assign step_quo = {quo_sh[WIDTH-1:1], ~trial_borrow};

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rem_work    <= '0;
         quo_work    <= '0;
         divisor_q   <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         rem_work    <= rem_n;
         quo_work    <= quo_n;
         divisor_q   <= divisor_n;
         count       <= count_n;
         quotient    <= quotient_n;
         remainder   <= remainder_n;
         div_by_zero <= dbz_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n     = state;
      rem_n       = rem_work;
      quo_n       = quo_work;
      divisor_n   = divisor_q;
      count_n     = count;
      quotient_n  = quotient;
      remainder_n = remainder;
      dbz_n       = div_by_zero;
      busy_n      = 1'b0;
      done_n      = 1'b0;
      accept      = 1'b0;

      case (state)
         IDLE: accept = start;
         CALC: begin
            rem_n   = step_rem;
            quo_n   = step_quo;
            count_n = count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
               state_n     = DONE;
               done_n      = 1'b1;
               quotient_n  = step_quo;
               remainder_n = step_rem;
               dbz_n       = 1'b0;
            end else begin
               busy_n = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            accept  = start;
         end
         default: state_n = IDLE;
      endcase

      // Accepting a start in DONE chains straight into the next operation.
      if (accept) begin
         if (divisor != '0) begin
            state_n   = CALC;
            busy_n    = 1'b1;
            rem_n     = '0;
            quo_n     = dividend;
            divisor_n = divisor;
            count_n   = '0;
         end else begin
            state_n     = DONE;
            done_n      = 1'b1;
            quotient_n  = WIDTH'(DBZ_QUOTIENT);
            remainder_n = dividend;
            dbz_n       = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_fails  = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] eq,
                               input logic [W-1:0] er, input logic edz);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_quo"},  32'(quotient), 32'(eq));
      check({tag, "_rem"},  32'(remainder), 32'(er));
      check({tag, "_dbz"},  32'(div_by_zero), 32'(edz));
   endtask

   // Full transaction: start in cycle 0, busy cycles 1..W (nonzero divisor), done after.
   task automatic do_div(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = ~dd;
      divisor  = ~dv;
      if (dv != '0) begin
         for (int c = 1; c <= int'(W); c++) begin
            check({tag, "_busy_calc"}, 32'(busy), 32'd1);
            check({tag, "_done_calc"}, 32'(done), 32'd0);
            tick();
         end
      end
      check_result(tag, eq, er, edz);
      tick();
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_quo_hold"},  32'(quotient), 32'(eq));
      check({tag, "_rem_hold"},  32'(remainder), 32'(er));
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quo",  32'(quotient), 32'd0);
      check("rst_rem",  32'(remainder), 32'd0);
      check("rst_dbz",  32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      tick();

      do_div("d13_3", 4'd13, 4'd3, 4'd4,  4'd1, 1'b0);
      do_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
      do_div("d5_7",  4'd5,  4'd7, 4'd0,  4'd5, 1'b0);
      do_div("d9_0",  4'd9,  4'd0, 4'd15, 4'd9, 1'b1);
      do_div("d8_2",  4'd8,  4'd2, 4'd4,  4'd0, 1'b0);

      // Start during CALC must be ignored.
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      dividend = 4'd3; divisor = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_busy_c3", 32'(busy), 32'd1);
      tick();
      tick();
      check_result("ign", 4'd2, 4'd2, 1'b0);
      tick();
      check("ign_one_done", 32'(done), 32'd0);
      check("ign_idle", 32'(busy), 32'd0);
      tick();
      check("ign_no_second", 32'(busy), 32'd0);

      // Asynchronous reset in cycle 2 of 14/3.
      dividend = 4'd14; divisor = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_quo",  32'(quotient), 32'd0);
      check("arst_rem",  32'(remainder), 32'd0);
      check("arst_dbz",  32'(div_by_zero), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      check("arst_idle", 32'(busy), 32'd0);
      do_div("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

      // Back-to-back: start held through DONE of 7/2 launches 6/4.
      dividend = 4'd7; divisor = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      dividend = 4'd6; divisor = 4'd4; start = 1'b1;
      tick();
      check_result("b2b_first", 4'd3, 4'd1, 1'b0);
      tick();
      start = 1'b0;
      check("b2b_busy_c1", 32'(busy), 32'd1);
      check("b2b_done_c1", 32'(done), 32'd0);
      tick();
      tick();
      tick();
      check("b2b_busy_c4", 32'(busy), 32'd1);
      tick();
      check_result("b2b_second", 4'd1, 4'd2, 1'b0);
      tick();
      check("b2b_done_drop", 32'(done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
